// File: rtl/axi_hp_pkg.sv
// Shared constants, FSM state types and burst-legality helper for the HP-port loopback responder.
package axi_hp_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] SIZE_4B     = 3'b010;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // A burst is legal only for 4-byte beats, FIXED/INCR, with every beat inside the window.
  function automatic logic burst_ok(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] depth_words,
                                    input logic [1:0]  burst,
                                    input logic [2:0]  size,
                                    input logic [3:0]  len);
    logic [31:0] word;
    word = (addr - base) >> 2;
    return (size == SIZE_4B) &&
           ((burst == BURST_FIXED) || (burst == BURST_INCR)) &&
           (word < depth_words) &&
           ((burst == BURST_FIXED) || ((word + {28'd0, len}) < depth_words));
  endfunction

endpackage

// File: rtl/axi_hp_responder_if.sv
// AXI3 HP-port signal bundle; master drives requests, slave returns ready/response.
interface axi_hp_responder_if #(parameter int ID_W = 6);

  logic [31:0]     AXI_awaddr;
  logic [1:0]      AXI_awburst;
  logic [2:0]      AXI_awsize;
  logic [3:0]      AXI_awlen;
  logic [ID_W-1:0] AXI_awid;
  logic [3:0]      AXI_awcache;
  logic [2:0]      AXI_awprot;
  logic [1:0]      AXI_awlock;
  logic [3:0]      AXI_awqos;
  logic            AXI_awvalid;
  logic            AXI_awready;

  logic [31:0]     AXI_wdata;
  logic [3:0]      AXI_wstrb;
  logic            AXI_wlast;
  logic [ID_W-1:0] AXI_wid;
  logic            AXI_wvalid;
  logic            AXI_wready;

  logic [ID_W-1:0] AXI_bid;
  logic [1:0]      AXI_bresp;
  logic            AXI_bvalid;
  logic            AXI_bready;

  logic [31:0]     AXI_araddr;
  logic [1:0]      AXI_arburst;
  logic [2:0]      AXI_arsize;
  logic [3:0]      AXI_arlen;
  logic [ID_W-1:0] AXI_arid;
  logic [3:0]      AXI_arcache;
  logic [2:0]      AXI_arprot;
  logic [1:0]      AXI_arlock;
  logic [3:0]      AXI_arqos;
  logic            AXI_arvalid;
  logic            AXI_arready;

  logic [31:0]     AXI_rdata;
  logic [ID_W-1:0] AXI_rid;
  logic [1:0]      AXI_rresp;
  logic            AXI_rlast;
  logic            AXI_rvalid;
  logic            AXI_rready;

  modport slave (
    input  AXI_awaddr, AXI_awburst, AXI_awsize, AXI_awlen, AXI_awid,
           AXI_awcache, AXI_awprot, AXI_awlock, AXI_awqos, AXI_awvalid,
    output AXI_awready,
    input  AXI_wdata, AXI_wstrb, AXI_wlast, AXI_wid, AXI_wvalid,
    output AXI_wready,
    output AXI_bid, AXI_bresp, AXI_bvalid,
    input  AXI_bready,
    input  AXI_araddr, AXI_arburst, AXI_arsize, AXI_arlen, AXI_arid,
           AXI_arcache, AXI_arprot, AXI_arlock, AXI_arqos, AXI_arvalid,
    output AXI_arready,
    output AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast, AXI_rvalid,
    input  AXI_rready
  );

  modport master (
    output AXI_awaddr, AXI_awburst, AXI_awsize, AXI_awlen, AXI_awid,
           AXI_awcache, AXI_awprot, AXI_awlock, AXI_awqos, AXI_awvalid,
    input  AXI_awready,
    output AXI_wdata, AXI_wstrb, AXI_wlast, AXI_wid, AXI_wvalid,
    input  AXI_wready,
    input  AXI_bid, AXI_bresp, AXI_bvalid,
    output AXI_bready,
    output AXI_araddr, AXI_arburst, AXI_arsize, AXI_arlen, AXI_arid,
           AXI_arcache, AXI_arprot, AXI_arlock, AXI_arqos, AXI_arvalid,
    input  AXI_arready,
    input  AXI_rdata, AXI_rid, AXI_rresp, AXI_rlast, AXI_rvalid,
    output AXI_rready
  );

endinterface

// File: rtl/axi_hp_responder_mem.sv
// DEPTH x 32 storage: one byte-enabled write port, one combinational read port.
module axi_resp_mem #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_hp_responder.sv
// AXI3 slave terminating 32-bit HP-port traffic into a local word memory.
// Write and read channels run independent FSMs and may be busy at the same time.
//
//   state  | meaning
//   W_IDLE | awready high, waiting for a write address
//   W_DATA | wready high, accepting beats until wlast or beat len+1
//   W_RESP | bvalid high, holding the write response until bready
//   R_IDLE | arready high, waiting for a read address
//   R_DATA | rvalid high, presenting beats until the rlast handshake
module axi_hp_responder
  import axi_hp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          ID_W      = 6
) (
  input logic               AXI_clk,
  input logic               AXI_rst_n,
  axi_hp_responder_if.slave axi
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  w_state_e        w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]      w_len, w_beat;
  logic            w_err, w_incr;
  logic [1:0]      w_bresp;
  logic            aw_hs, w_hs, b_hs, w_last_beat, w_end;
  logic [31:0]     aw_off;
  logic [3:0]      mem_we;

  r_state_e        r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [IDX_W-1:0] r_idx, r_idx_nxt, mem_raddr;
  logic [3:0]      r_len, r_beat;
  logic            r_err, r_incr;
  logic [31:0]     r_data, mem_rdata, ar_off;
  logic            ar_hs, r_hs, r_last, ar_ok;

  assign aw_off      = axi.AXI_awaddr - BASE_ADDR;
  assign aw_hs       = axi.AXI_awvalid && (w_state == W_IDLE);
  assign w_hs        = axi.AXI_wvalid  && (w_state == W_DATA);
  assign b_hs        = axi.AXI_bready  && (w_state == W_RESP);
  assign w_last_beat = (w_beat == w_len);
  assign w_end       = axi.AXI_wlast || w_last_beat;
  assign mem_we      = (w_hs && !w_err) ? axi.AXI_wstrb : 4'b0000;

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) w_state <= W_IDLE;
    else            w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)          w_next = W_DATA;
      W_DATA:  if (w_hs && w_end)  w_next = W_RESP;
      W_RESP:  if (b_hs)           w_next = W_IDLE;
      default:                     w_next = W_IDLE;
    endcase
  end

  always_comb begin
    axi.AXI_awready = (w_state == W_IDLE);
    axi.AXI_wready  = (w_state == W_DATA);
    axi.AXI_bvalid  = (w_state == W_RESP);
    axi.AXI_bid     = w_id;
    axi.AXI_bresp   = w_bresp;
  end

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      w_incr  <= 1'b0;
      w_bresp <= RESP_OKAY;
    end else if (aw_hs) begin
      w_id   <= axi.AXI_awid;
      w_idx  <= aw_off[IDX_W+1:2];
      w_len  <= axi.AXI_awlen;
      w_beat <= '0;
      w_err  <= !burst_ok(axi.AXI_awaddr, BASE_ADDR, DEPTH_W, axi.AXI_awburst,
                          axi.AXI_awsize, axi.AXI_awlen);
      w_incr <= (axi.AXI_awburst == BURST_INCR);
    end else if (w_hs) begin
      w_beat <= w_beat + 4'd1;
      if (w_incr) w_idx <= w_idx + IDX_W'(1);
      // A wlast that disagrees with the beat count fails the whole burst.
      if (w_end) w_bresp <= (w_err || (axi.AXI_wlast != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign ar_off    = axi.AXI_araddr - BASE_ADDR;
  assign ar_hs     = axi.AXI_arvalid && (r_state == R_IDLE);
  assign r_hs      = axi.AXI_rready  && (r_state == R_DATA);
  assign r_last    = (r_beat == r_len);
  assign ar_ok     = burst_ok(axi.AXI_araddr, BASE_ADDR, DEPTH_W, axi.AXI_arburst,
                              axi.AXI_arsize, axi.AXI_arlen);
  assign r_idx_nxt = r_incr ? r_idx + IDX_W'(1) : r_idx;
  // Read data is fetched one beat ahead and registered so R stays frozen under backpressure.
  assign mem_raddr = (r_state == R_IDLE) ? ar_off[IDX_W+1:2] : r_idx_nxt;

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) r_state <= R_IDLE;
    else            r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)           r_next = R_DATA;
      R_DATA:  if (r_hs && r_last)  r_next = R_IDLE;
      default:                      r_next = R_IDLE;
    endcase
  end

  always_comb begin
    axi.AXI_arready = (r_state == R_IDLE);
    axi.AXI_rvalid  = (r_state == R_DATA);
    axi.AXI_rlast   = (r_state == R_DATA) && r_last;
    axi.AXI_rresp   = ((r_state == R_DATA) && r_err) ? RESP_SLVERR : RESP_OKAY;
    axi.AXI_rid     = r_id;
    axi.AXI_rdata   = r_data;
  end

  always_ff @(posedge AXI_clk) begin
    if (!AXI_rst_n) begin
      r_id   <= '0;
      r_idx  <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_err  <= 1'b0;
      r_incr <= 1'b0;
      r_data <= '0;
    end else if (ar_hs) begin
      r_id   <= axi.AXI_arid;
      r_idx  <= ar_off[IDX_W+1:2];
      r_len  <= axi.AXI_arlen;
      r_beat <= '0;
      r_err  <= !ar_ok;
      r_incr <= (axi.AXI_arburst == BURST_INCR);
      r_data <= ar_ok ? mem_rdata : 32'd0;
    end else if (r_hs && !r_last) begin
      r_beat <= r_beat + 4'd1;
      r_idx  <= r_idx_nxt;
      r_data <= r_err ? 32'd0 : mem_rdata;
    end
  end

  axi_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (AXI_clk),
    .we    (mem_we),
    .waddr (w_idx),
    .wdata (axi.AXI_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  logic unused_bits;
  assign unused_bits = ^{aw_off[31:IDX_W+2], aw_off[1:0], ar_off[31:IDX_W+2], ar_off[1:0],
                         axi.AXI_wid, axi.AXI_awcache, axi.AXI_awprot, axi.AXI_awlock,
                         axi.AXI_awqos, axi.AXI_arcache, axi.AXI_arprot, axi.AXI_arlock,
                         axi.AXI_arqos};

endmodule
